// File: rtl/thin_window_feeder_if.sv
// Stream bundle for thin_window_feeder: raster word input and registered top/center/bottom window output.
// master drives the input words and out_ready; slave is the feeder itself.
interface thin_window_feeder_if #(
    parameter int WORDS_PER_ROW = 10,
    parameter int ROWS          = 240
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(WORDS_PER_ROW);

    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          in_sof;

    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_top;
    logic [31:0]   out_center;
    logic [31:0]   out_bottom;
    logic [RW-1:0] out_row;
    logic [CW-1:0] out_col;
    logic          out_eof;

    modport master (
        output in_valid, in_data, in_sof, out_ready,
        input  in_ready, out_valid, out_top, out_center, out_bottom, out_row, out_col, out_eof
    );

    modport slave (
        input  in_valid, in_data, in_sof, out_ready,
        output in_ready, out_valid, out_top, out_center, out_bottom, out_row, out_col, out_eof
    );
endinterface

// File: rtl/thin_window_feeder.sv
// Row-window builder feeding the ALU thinning inputs A/B/C from a 32-px-per-word raster.
// Define THIN_BORDER_PAD_EN to also emit zero-padded windows for center rows 0 and ROWS-1 (adds FLUSH).
module thin_window_feeder #(
    parameter int WORDS_PER_ROW = 10,
    parameter int ROWS          = 240
) (
    input logic                 clk,
    input logic                 reset_n,
    thin_window_feeder_if.slave bus
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(WORDS_PER_ROW);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);
    localparam logic [CW-1:0] LAST_COL = CW'(WORDS_PER_ROW - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);

`ifdef THIN_BORDER_PAD_EN
    localparam bit PAD_EN = 1'b1;
    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH} state_t;
`else
    localparam bit PAD_EN = 1'b0;
    typedef enum logic [1:0] {S_IDLE, S_STREAM} state_t;
`endif

    state_t        state_q, state_d;
    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic [31:0]   buf_top [WORDS_PER_ROW];
    logic [31:0]   buf_ctr [WORDS_PER_ROW];

    logic          out_valid_q;
    logic [31:0]   out_top_q, out_ctr_q, out_bot_q;
    logic [RW-1:0] out_row_q;
    logic [CW-1:0] out_col_q;
    logic          out_eof_q;

    logic          out_free, in_ready_c, accept, restart, take, last_word;
    logic [RW-1:0] cur_row;
    logic [CW-1:0] cur_col;
    logic          emit;
    logic [31:0]   win_top, win_ctr, win_bot;
    logic [RW-1:0] win_row;
    logic [CW-1:0] win_col;
    logic          win_eof;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (restart) state_d = S_STREAM;
`ifdef THIN_BORDER_PAD_EN
            S_FLUSH:  if (out_free && col_q == LAST_COL) state_d = S_IDLE;
`endif
            default:  state_d = state_q;
        endcase
        if (last_word) state_d = PAD_EN ? state_t'(2) : S_IDLE;
    end

    // An accepted in_sof always re-anchors the word at row 0, col 0, whatever the state.
    always_comb begin
        out_free   = !out_valid_q || bus.out_ready;
        in_ready_c = out_free;
`ifdef THIN_BORDER_PAD_EN
        if (state_q == S_FLUSH) in_ready_c = 1'b0;
`endif
        accept    = bus.in_valid && in_ready_c;
        restart   = accept && bus.in_sof;
        take      = restart || (accept && state_q == S_STREAM);
        cur_row   = restart ? '0 : row_q;
        cur_col   = restart ? '0 : col_q;
        last_word = take && (cur_row == LAST_ROW) && (cur_col == LAST_COL);

        emit    = 1'b0;
        win_top = '0;
        win_ctr = '0;
        win_bot = '0;
        win_row = '0;
        win_col = '0;
        win_eof = 1'b0;
        if (take && cur_row >= ROW_TWO) begin
            emit    = 1'b1;
            win_top = buf_top[cur_col];
            win_ctr = buf_ctr[cur_col];
            win_bot = bus.in_data;
            win_row = cur_row - ROW_ONE;
            win_col = cur_col;
            win_eof = last_word && !PAD_EN;
        end
`ifdef THIN_BORDER_PAD_EN
        else if (take && cur_row == ROW_ONE) begin
            emit    = 1'b1;
            win_ctr = buf_ctr[cur_col];
            win_bot = bus.in_data;
            win_col = cur_col;
        end
        if (state_q == S_FLUSH && out_free) begin
            emit    = 1'b1;
            win_top = buf_top[col_q];
            win_ctr = buf_ctr[col_q];
            win_row = LAST_ROW;
            win_col = col_q;
            win_eof = (col_q == LAST_COL);
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_q <= '0;
            col_q <= '0;
        end else if (take) begin
            if (last_word) begin
                row_q <= '0;
                col_q <= '0;
            end else if (cur_col == LAST_COL) begin
                row_q <= cur_row + ROW_ONE;
                col_q <= '0;
            end else begin
                row_q <= cur_row;
                col_q <= cur_col + COL_ONE;
            end
        end
`ifdef THIN_BORDER_PAD_EN
        else if (state_q == S_FLUSH && out_free) begin
            col_q <= (col_q == LAST_COL) ? '0 : col_q + COL_ONE;
        end
`endif
    end

    // Row buffers need no reset: emission is gated on the row counter, so stale words never leave.
    always_ff @(posedge clk) begin
        if (take) begin
            buf_top[cur_col] <= buf_ctr[cur_col];
            buf_ctr[cur_col] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_top_q   <= '0;
            out_ctr_q   <= '0;
            out_bot_q   <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_eof_q   <= 1'b0;
        end else if (emit) begin
            out_valid_q <= 1'b1;
            out_top_q   <= win_top;
            out_ctr_q   <= win_ctr;
            out_bot_q   <= win_bot;
            out_row_q   <= win_row;
            out_col_q   <= win_col;
            out_eof_q   <= win_eof;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_top    = out_top_q;
    assign bus.out_center = out_ctr_q;
    assign bus.out_bottom = out_bot_q;
    assign bus.out_row    = out_row_q;
    assign bus.out_col    = out_col_q;
    assign bus.out_eof    = out_eof_q;
endmodule
